// File: rtl/hme_ip_rx_frame_buf_v4_if.sv
// RX frame buffer bus: MAC-side write port plus reader-side frame/word access.
interface hme_ip_rx_frame_buf_v4_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 10
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_eof;
  logic          wr_good;
  logic          rx_frm_ok;
  logic          rx_frm_drop;
  logic [AW:0]   free_words;
  logic          rd_avail;
  logic [LW-1:0] rd_len;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          rd_done;

  modport slave (
    input  wr_en, wr_data, wr_eof, wr_good, rd_en, rd_done,
    output rx_frm_ok, rx_frm_drop, free_words, rd_avail, rd_len, rd_data, rd_vld
  );

  modport master (
    output wr_en, wr_data, wr_eof, wr_good, rd_en, rd_done,
    input  rx_frm_ok, rx_frm_drop, free_words, rd_avail, rd_len, rd_data, rd_vld
  );
endinterface

// File: rtl/hme_ip_rx_frame_buf_v4.sv
// Circular RX frame buffer with commit/rollback per frame and a queue of committed lengths.
// RAM depth is arbitrary; all pointer arithmetic wraps explicitly at DEPTH.
module hme_ip_rx_frame_buf_v4 #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 768,
  parameter int unsigned AW    = 10,
  parameter int unsigned LW    = 10,
  parameter int unsigned NFRM  = 8
) (
  input logic                      clk,
  input logic                      rst,
  hme_ip_rx_frame_buf_v4_if.slave  bus
);

  localparam int unsigned QW = $clog2(NFRM);
  localparam int unsigned SW = AW + 2;
  localparam logic [AW:0]   DepthO = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] DepthS = SW'(DEPTH);
  localparam logic [QW:0]   NfrmQ  = (QW+1)'(NFRM);

  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [SW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(p) + n;
    if (s >= DepthS) s = s - DepthS;
    return s[AW-1:0];
  endfunction

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wp_c, wp_t, rp_f;
  logic [AW:0]   tcnt;
  logic [AW:0]   occ;
  logic [LW-1:0] rd_off;
  logic          drop;
  logic [LW-1:0] len_q [NFRM];
  logic [QW-1:0] q_wr, q_rd;
  logic [QW:0]   q_cnt;
  logic          frm_ok_q, frm_drop_q;
  logic [AW:0]   free_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_vld_q;

  logic          avail, rel, rd_fire;
  logic          wr_acc, wr_ovf, eof, commit, rollback;
  logic [LW-1:0] head_len, commit_len;
  logic [AW-1:0] wp_t_inc, rd_addr;
  logic [AW:0]   occ_d;

  always_comb begin
    avail      = (q_cnt != '0);
    head_len   = avail ? len_q[q_rd] : '0;
    rel        = bus.rd_done && avail;
    rd_fire    = bus.rd_en && avail && !bus.rd_done && (rd_off < head_len);
    wr_acc     = bus.wr_en && !drop && (occ < DepthO);
    wr_ovf     = bus.wr_en && !drop && (occ == DepthO);
    eof        = bus.wr_en && bus.wr_eof;
    commit     = eof && bus.wr_good && wr_acc && (q_cnt != NfrmQ);
    rollback   = eof && !commit;
    commit_len = LW'(tcnt + (AW+1)'(1));
    wp_t_inc   = ptr_add(wp_t, SW'(1));
    rd_addr    = ptr_add(rp_f, SW'(rd_off));
    // Rollback removes every tentative word, including one accepted this cycle.
    occ_d = occ + (AW+1)'(wr_acc)
          - (rollback ? (tcnt + (AW+1)'(wr_acc)) : '0)
          - (rel ? (AW+1)'(head_len) : '0);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp_t] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_c       <= '0;
      wp_t       <= '0;
      rp_f       <= '0;
      tcnt       <= '0;
      occ        <= '0;
      rd_off     <= '0;
      drop       <= 1'b0;
      q_wr       <= '0;
      q_rd       <= '0;
      q_cnt      <= '0;
      frm_ok_q   <= 1'b0;
      frm_drop_q <= 1'b0;
      free_q     <= DepthO;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      frm_ok_q   <= commit;
      frm_drop_q <= rollback;
      occ        <= occ_d;
      free_q     <= DepthO - occ_d;
      q_cnt      <= q_cnt + (QW+1)'(commit) - (QW+1)'(rel);

      if (wr_ovf) drop <= 1'b1;
      if (rollback) begin
        wp_t <= wp_c;
        tcnt <= '0;
        drop <= 1'b0;
      end else if (commit) begin
        wp_t        <= wp_t_inc;
        wp_c        <= wp_t_inc;
        tcnt        <= '0;
        len_q[q_wr] <= commit_len;
        q_wr        <= q_wr + QW'(1);
      end else if (wr_acc) begin
        wp_t <= wp_t_inc;
        tcnt <= tcnt + (AW+1)'(1);
      end

      if (rel) begin
        q_rd   <= q_rd + QW'(1);
        rp_f   <= ptr_add(rp_f, SW'(head_len));
        rd_off <= '0;
      end else if (rd_fire) begin
        rd_off <= rd_off + LW'(1);
      end

      rd_vld_q <= rd_fire;
      if (rd_fire) rd_data_q <= mem[rd_addr];
    end
  end

  assign bus.rx_frm_ok   = frm_ok_q;
  assign bus.rx_frm_drop = frm_drop_q;
  assign bus.free_words  = free_q;
  assign bus.rd_avail    = avail;
  assign bus.rd_len      = head_len;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_vld      = rd_vld_q;

endmodule

// File: tb/tb_hme_ip_rx_frame_buf_v4.sv
// Bench for hme_ip_rx_frame_buf_v4: queue-based frame model checked every cycle on a 20-deep
// instance, plus a 768-deep instance sharing the stimulus for the basic frame tests.
module tb_hme_ip_rx_frame_buf_v4;
  localparam int unsigned DW = 32, DEPTH = 20, AW = 5, LW = 5, NFRM = 8;
  localparam int unsigned BIG_DEPTH = 768, BIG_AW = 10, BIG_LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, wr_eof = 1'b0, wr_good = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  hme_ip_rx_frame_buf_v4_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();
  hme_ip_rx_frame_buf_v4_if #(.DW(DW), .AW(BIG_AW), .LW(BIG_LW)) big ();

  assign bus.wr_en   = wr_en;
  assign bus.wr_data = wr_data;
  assign bus.wr_eof  = wr_eof;
  assign bus.wr_good = wr_good;
  assign bus.rd_en   = rd_en;
  assign bus.rd_done = rd_done;
  assign big.wr_en   = wr_en;
  assign big.wr_data = wr_data;
  assign big.wr_eof  = wr_eof;
  assign big.wr_good = wr_good;
  assign big.rd_en   = rd_en;
  assign big.rd_done = rd_done;

  hme_ip_rx_frame_buf_v4 #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LW(LW), .NFRM(NFRM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hme_ip_rx_frame_buf_v4 #(.DW(DW), .DEPTH(BIG_DEPTH), .AW(BIG_AW), .LW(BIG_LW), .NFRM(NFRM))
    dut_big (
    .clk (clk),
    .rst (rst),
    .bus (big)
  );

  always #5 clk = ~clk;

  // Model: committed words in arrival order, per-frame lengths, and the frame being received.
  logic [DW-1:0] m_data [$];
  int            m_len  [$];
  logic [DW-1:0] m_tent [$];
  bit            m_drop;
  int            m_off;
  bit            cmp_on = 1'b0;
  logic          exp_ok, exp_drop, exp_vld, exp_avail;
  logic [DW-1:0] exp_data;
  int            exp_free, exp_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int occ, hl;
    bit avail, rel, fire, acc, commit;
    if (rst) begin
      m_data.delete();
      m_len.delete();
      m_tent.delete();
      m_drop   = 1'b0;
      m_off    = 0;
      exp_ok   = 1'b0;
      exp_drop = 1'b0;
      exp_vld  = 1'b0;
      exp_data = '0;
      cmp_on   = 1'b1;
    end else begin
      occ    = m_data.size() + m_tent.size();
      avail  = m_len.size() != 0;
      hl     = avail ? m_len[0] : 0;
      rel    = rd_done && avail;
      fire   = rd_en && avail && !rd_done && (m_off < hl);
      exp_vld = fire;
      if (fire) begin
        exp_data = m_data[m_off];
        m_off++;
      end
      exp_ok   = 1'b0;
      exp_drop = 1'b0;
      commit   = 1'b0;
      if (wr_en) begin
        acc = !m_drop && (occ < DEPTH);
        if (!m_drop && occ == DEPTH) m_drop = 1'b1;
        if (acc) m_tent.push_back(wr_data);
        if (wr_eof) begin
          commit = wr_good && acc && (m_len.size() < NFRM);
          if (commit) exp_ok = 1'b1;
          else begin
            exp_drop = 1'b1;
            m_tent.delete();
            m_drop = 1'b0;
          end
        end
      end
      if (rel) begin
        for (int i = 0; i < hl; i++) void'(m_data.pop_front());
        void'(m_len.pop_front());
        m_off = 0;
      end
      if (commit) begin
        m_len.push_back(m_tent.size());
        foreach (m_tent[i]) m_data.push_back(m_tent[i]);
        m_tent.delete();
      end
    end
    exp_free  = DEPTH - (m_data.size() + m_tent.size());
    exp_avail = m_len.size() != 0;
    exp_len   = exp_avail ? m_len[0] : 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("rx_frm_ok", bus.rx_frm_ok, exp_ok);
      chk("rx_frm_drop", bus.rx_frm_drop, exp_drop);
      chk("free_words", bus.free_words, exp_free);
      chk("rd_avail", bus.rd_avail, exp_avail);
      chk("rd_len", bus.rd_len, exp_len);
      chk("rd_vld", bus.rd_vld, exp_vld);
      chk("rd_data", bus.rd_data, exp_data);
    end
  end

  // Inputs change just after a falling edge and hold across the next rising edge.
  task automatic step(input bit we, input logic [DW-1:0] d, input bit eof, input bit good,
                      input bit re, input bit dn);
    wr_en   = we;
    wr_data = d;
    wr_eof  = eof;
    wr_good = good;
    rd_en   = re;
    rd_done = dn;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_frame(input int n, input int base, input bit good);
    for (int i = 0; i < n; i++) step(1'b1, DW'(base + i), i == n - 1, good, 1'b0, 1'b0);
  endtask

  task automatic read_head();
    int n;
    n = exp_len;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_free", bus.free_words, 20);
    chk("rst_free_big", big.free_words, 768);
    chk("rst_avail", bus.rd_avail, 0);
    chk("rst_len", bus.rd_len, 0);
    chk("rst_vld", bus.rd_vld, 0);
    chk("rst_data", bus.rd_data, 0);
    chk("model_rst_free", exp_free, 20);
    idle();

    // 16-word good frame, data 0..15
    write_frame(16, 0, 1'b1);
    chk("ok16", bus.rx_frm_ok, 1);
    chk("ok16_big", big.rx_frm_ok, 1);
    chk("len16", bus.rd_len, 16);
    chk("len16_big", big.rd_len, 16);
    chk("model_len16", exp_len, 16);
    idle();
    chk("ok16_pulse_end", bus.rx_frm_ok, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rd16_vld", bus.rd_vld, 1);
      chk("rd16_data", bus.rd_data, i);
      chk("rd16_data_big", big.rd_data, i);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rel16_free", bus.free_words, 20);
    chk("rel16_free_big", big.free_words, 768);
    chk("rel16_avail", bus.rd_avail, 0);

    // 10-word bad frame
    write_frame(10, 100, 1'b0);
    chk("bad_drop", bus.rx_frm_drop, 1);
    chk("bad_drop_big", big.rx_frm_drop, 1);
    chk("bad_avail", bus.rd_avail, 0);
    chk("bad_free", bus.free_words, 20);
    chk("bad_free_big", big.free_words, 768);
    idle();

    // 15-word frame fills most of the RAM; next 10-word frame overflows at word 6
    write_frame(15, 200, 1'b1);
    write_frame(10, 300, 1'b1);
    chk("ovf_drop", bus.rx_frm_drop, 1);
    chk("ovf_ok_big", big.rx_frm_ok, 1);
    chk("ovf_free", bus.free_words, 5);
    chk("ovf_len", bus.rd_len, 15);
    read_head();

    // Repeated 15-word frames wrap around the end of the RAM
    for (int k = 0; k < 3; k++) begin
      write_frame(15, 400 + 16 * k, 1'b1);
      chk("wrap_len", bus.rd_len, 15);
      read_head();
      chk("wrap_free", bus.free_words, 20);
    end

    // Fill the length queue with one-word frames; the ninth drops
    for (int i = 0; i < 8; i++) write_frame(1, 500 + i, 1'b1);
    chk("qfull_free", bus.free_words, 12);
    write_frame(1, 600, 1'b1);
    chk("qfull_drop", bus.rx_frm_drop, 1);
    chk("qfull_free_after", bus.free_words, 12);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    write_frame(1, 601, 1'b1);
    chk("qfree_ok", bus.rx_frm_ok, 1);
    chk("qfree_free", bus.free_words, 12);
    repeat (NFRM + 1) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_free", bus.free_words, 20);

    // Commit in the same cycle as release of the previous frame
    write_frame(3, 700, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(710 + i), i == 3, 1'b1, 1'b0, i == 3);
    chk("simul_ok", bus.rx_frm_ok, 1);
    chk("simul_avail", bus.rd_avail, 1);
    chk("simul_len", bus.rd_len, 4);
    chk("simul_free", bus.free_words, 16);
    read_head();

    // Reset in the middle of a frame
    write_frame(1, 800, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(810 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    chk("mrst_drop", bus.rx_frm_drop, 0);
    chk("mrst_free", bus.free_words, 20);
    chk("mrst_avail", bus.rd_avail, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit we, eof, good, re, dn;
      we   = $urandom_range(0, 9) < 6;
      eof  = we && ($urandom_range(0, 4) == 0);
      good = $urandom_range(0, 4) != 0;
      re   = $urandom_range(0, 1) == 1;
      dn   = $urandom_range(0, 19) == 0;
      step(we, DW'($urandom), eof, good, re, dn);
    end
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
